// File: rtl/rc4_breaker_pkg.sv
// ============================================================================
// Module   : rc4_breaker_pkg
// Purpose  : Shared types and character constants for the RC4 key-search slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rc4_breaker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_EVAL      = 3'd3,
        ST_NEXT      = 3'd4,
        ST_FOUND     = 3'd5,
        ST_EXHAUSTED = 3'd6
    } search_state_t;

    localparam logic [7:0] CHAR_SPACE      = 8'h20;
    localparam logic [7:0] CHAR_LOWER_A    = 8'h61;
    localparam logic [7:0] CHAR_LOWER_Z    = 8'h7A;
    localparam int         DEFAULT_MSG_LEN = 32;

    // Plaintext alphabet: space plus lowercase letters.
    function automatic logic is_legal_char(input logic [7:0] c);
        return (c == CHAR_SPACE) || ((c >= CHAR_LOWER_A) && (c <= CHAR_LOWER_Z));
    endfunction

endpackage

`default_nettype wire

// File: rtl/plaintext_checker.sv
// ============================================================================
// Module   : plaintext_checker
// Purpose  : Counts decrypted characters and flags any illegal or excess one.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module plaintext_checker
    import rc4_breaker_pkg::*;
#(
    parameter int MSG_LEN = DEFAULT_MSG_LEN
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       pass,
    output logic       bad
);

    localparam int             CNT_W       = $clog2(MSG_LEN + 1);
    localparam logic [CNT_W-1:0] c_MSG_LEN = CNT_W'(MSG_LEN);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_char_cnt;
    logic             r_bad;
    logic             w_accept;
    logic             w_full;
    logic             w_bad_now;

    assign w_accept  = enable && char_valid;
    assign w_full    = (r_char_cnt == c_MSG_LEN);
    assign w_bad_now = w_accept && (!is_legal_char(char_data) || w_full);

    // The count saturates at MSG_LEN; anything beyond is caught by the bad flag.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n || clear) begin
            r_char_cnt <= '0;
            r_bad      <= 1'b0;
        end else begin
            if (w_accept && !w_full) begin
                r_char_cnt <= r_char_cnt + c_CNT_ONE;
            end
            if (w_bad_now) begin
                r_bad <= 1'b1;
            end
        end
    end

    // bad also reflects the character being screened this cycle.
    assign bad  = r_bad || w_bad_now;
    assign pass = !r_bad && w_full;

endmodule

`default_nettype wire

// File: rtl/key_search_scheduler.sv
// ============================================================================
// Module   : key_search_scheduler
// Purpose  : Steps RC4 candidate keys and stops on the first printable message.
//            Optional build macro: EARLY_REJECT_EN (abandon a key on first bad char).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_search_scheduler
    import rc4_breaker_pkg::*;
#(
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_START = 24'h000000,
    parameter logic [KEY_WIDTH-1:0] KEY_END   = 24'h3FFFFF,
    parameter int                   MSG_LEN   = DEFAULT_MSG_LEN
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 decrypt_done,
    input  logic                 char_valid,
    input  logic [7:0]           char_data,
    output logic [KEY_WIDTH-1:0] secret_key,
    output logic                 key_changed,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic [KEY_WIDTH-1:0] found_key,
    output logic [KEY_WIDTH:0]   keys_tried
);

    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_LOAD      = ST_LOAD;
    localparam logic [2:0] S_RUN       = ST_RUN;
    localparam logic [2:0] S_EVAL      = ST_EVAL;
    localparam logic [2:0] S_NEXT      = ST_NEXT;
    localparam logic [2:0] S_FOUND     = ST_FOUND;
    localparam logic [2:0] S_EXHAUSTED = ST_EXHAUSTED;

    localparam logic [KEY_WIDTH-1:0] c_KEY_ONE   = KEY_WIDTH'(1);
    localparam logic [KEY_WIDTH:0]   c_TRIED_ONE = (KEY_WIDTH + 1)'(1);

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [KEY_WIDTH-1:0] r_key;
    logic [KEY_WIDTH-1:0] r_found_key;
    logic [KEY_WIDTH:0]   r_keys_tried;
    logic                 w_pass;
    logic                 w_bad;
    logic                 w_start_ok;
    logic                 w_key_passed;
    logic                 w_count_key;
    logic                 w_at_end;

    plaintext_checker #(
        .MSG_LEN (MSG_LEN)
    ) u_checker (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .clear      (r_state == S_LOAD),
        .enable     (r_state == S_RUN),
        .char_valid (char_valid),
        .char_data  (char_data),
        .pass       (w_pass),
        .bad        (w_bad)
    );

    assign w_start_ok   = start && ((r_state == S_IDLE) || (r_state == S_FOUND) ||
                                    (r_state == S_EXHAUSTED));
    assign w_key_passed = (r_state == S_EVAL) && w_pass && !w_bad;
    assign w_at_end     = (r_key == KEY_END);

`ifdef EARLY_REJECT_EN
    assign w_count_key = (r_state == S_EVAL) || ((r_state == S_RUN) && w_bad);
`else
    assign w_count_key = (r_state == S_EVAL);
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next_state = S_LOAD;
            S_LOAD:      w_next_state = S_RUN;
            S_RUN: begin
`ifdef EARLY_REJECT_EN
                if (w_bad)             w_next_state = S_NEXT;
                else if (decrypt_done) w_next_state = S_EVAL;
`else
                if (decrypt_done)      w_next_state = S_EVAL;
`endif
            end
            S_EVAL:      w_next_state = w_key_passed ? S_FOUND : S_NEXT;
            S_NEXT:      w_next_state = w_at_end ? S_EXHAUSTED : S_LOAD;
            S_FOUND:     if (start) w_next_state = S_LOAD;
            S_EXHAUSTED: if (start) w_next_state = S_LOAD;
            default:     w_next_state = S_IDLE;
        endcase
        if (abort) begin
            w_next_state = S_IDLE;
        end
    end

    // Abort freezes the datapath so the aborted candidate leaves no trace.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_key        <= KEY_START;
            r_found_key  <= '0;
            r_keys_tried <= '0;
        end else begin
            r_state <= w_next_state;
            if (!abort) begin
                if (w_start_ok) begin
                    r_key        <= KEY_START;
                    r_found_key  <= '0;
                    r_keys_tried <= '0;
                end
                if (w_count_key) begin
                    r_keys_tried <= r_keys_tried + c_TRIED_ONE;
                end
                if (w_key_passed) begin
                    r_found_key <= r_key;
                end
                if ((r_state == S_NEXT) && !w_at_end) begin
                    r_key <= r_key + c_KEY_ONE;
                end
            end
        end
    end

    assign secret_key  = r_key;
    assign key_changed = (r_state == S_LOAD);
    assign key_valid   = (r_state == S_RUN);
    assign busy        = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_NEXT);
    assign found       = (r_state == S_FOUND);
    assign exhausted   = (r_state == S_EXHAUSTED);
    assign found_key   = r_found_key;
    assign keys_tried  = r_keys_tried;

endmodule

`default_nettype wire

// File: tb/tb_key_search_scheduler.sv
// ============================================================================
// Module   : tb_key_search_scheduler
// Purpose  : Directed self-checking bench, KEY_START=0, KEY_END=3, MSG_LEN=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_search_scheduler;

    localparam int KW = 24;

    logic          CLOCK_50 = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic          decrypt_done;
    logic          char_valid;
    logic [7:0]    char_data;
    logic [KW-1:0] secret_key;
    logic          key_changed;
    logic          key_valid;
    logic          busy;
    logic          found;
    logic          exhausted;
    logic [KW-1:0] found_key;
    logic [KW:0]   keys_tried;

    int n_checks = 0;
    int n_fail   = 0;
    int kc_high  = 0;
    int kc_pulse = 0;
    logic kc_prev = 1'b0;
    int snap_high;
    int snap_pulse;

    always #5 CLOCK_50 = ~CLOCK_50;

    key_search_scheduler #(
        .KEY_WIDTH (KW),
        .KEY_START (24'd0),
        .KEY_END   (24'd3),
        .MSG_LEN   (4)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .decrypt_done (decrypt_done),
        .char_valid   (char_valid),
        .char_data    (char_data),
        .secret_key   (secret_key),
        .key_changed  (key_changed),
        .key_valid    (key_valid),
        .busy         (busy),
        .found        (found),
        .exhausted    (exhausted),
        .found_key    (found_key),
        .keys_tried   (keys_tried)
    );

    // Counts high cycles and rising edges of key_changed.
    always @(posedge CLOCK_50) begin
        if (key_changed) kc_high <= kc_high + 1;
        if (key_changed && !kc_prev) kc_pulse <= kc_pulse + 1;
        kc_prev <= key_changed;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (key_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(key_valid), 32'd1);
    endtask

    // Presents n characters of msg (MSB first), then decrypt_done.
    task automatic feed(input logic [31:0] msg, input int n, input bit coincide);
        for (int i = 0; i < n; i++) begin
            char_valid   = 1'b1;
            char_data    = msg[31-8*i -: 8];
            decrypt_done = coincide && (i == n - 1);
            tick();
        end
        char_valid   = 1'b0;
        decrypt_done = 1'b0;
        if (!coincide) begin
            decrypt_done = 1'b1;
            tick();
            decrypt_done = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_secret_key"}, 32'(secret_key), 32'd0);
        check({pfx, "_found_key"},  32'(found_key),  32'd0);
        check({pfx, "_keys_tried"}, 32'(keys_tried), 32'd0);
        check({pfx, "_key_changed"},32'(key_changed),32'd0);
        check({pfx, "_key_valid"},  32'(key_valid),  32'd0);
        check({pfx, "_busy"},       32'(busy),       32'd0);
        check({pfx, "_found"},      32'(found),      32'd0);
        check({pfx, "_exhausted"},  32'(exhausted),  32'd0);
    endtask

    initial begin
        logic [31:0] good_msg;
        logic [31:0] bad_msg;
        good_msg     = "ab c";
        bad_msg      = "AB!c";
        reset_n      = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        decrypt_done = 1'b0;
        char_valid   = 1'b0;
        char_data    = 8'h00;
        tick();
        tick();
        check_reset_outputs("rst");
        reset_n = 1'b1;
        tick();

        // Key 2 is the only printable one.
        snap_high  = kc_high;
        snap_pulse = kc_pulse;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_key_changed", 32'(key_changed), 32'd1);
        check("load_busy",        32'(busy),        32'd1);
        tick();
        check("run_key_valid",    32'(key_valid),   32'd1);
        check("run_key_changed",  32'(key_changed), 32'd0);
        for (int k = 0; k < 3; k++) begin
            wait_run("s1_wait_run");
            check("s1_secret_key", 32'(secret_key), 32'(k));
            feed((k == 2) ? good_msg : bad_msg, 4, 1'b0);
        end
        tick();
        check("s1_found",      32'(found),      32'd1);
        check("s1_found_key",  32'(found_key),  32'd2);
        check("s1_keys_tried", 32'(keys_tried), 32'd3);
        check("s1_busy",       32'(busy),       32'd0);
        check("s1_kc_pulses",  32'(kc_pulse - snap_pulse), 32'd3);
        check("s1_kc_cycles",  32'(kc_high - snap_high),   32'd3);

        // No key passes: space exhausted.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s2_tried_clear", 32'(keys_tried), 32'd0);
        check("s2_secret_key0", 32'(secret_key), 32'd0);
        for (int k = 0; k < 4; k++) begin
            wait_run("s2_wait_run");
            feed(bad_msg, 4, 1'b0);
        end
        tick();
        tick();
        check("s2_exhausted",  32'(exhausted),  32'd1);
        check("s2_keys_tried", 32'(keys_tried), 32'd4);
        check("s2_found",      32'(found),      32'd0);
        check("s2_secret_key", 32'(secret_key), 32'd3);

        // Short message (3 legal chars) is rejected.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_run("s3_wait_run");
        feed(good_msg, 3, 1'b0);
        tick();
        tick();
        check("s3_key_changed", 32'(key_changed), 32'd1);
        check("s3_secret_key",  32'(secret_key),  32'd1);
        check("s3_keys_tried",  32'(keys_tried),  32'd1);

        // Abort with start in RUN of key 1.
        tick();
        check("s5_in_run", 32'(key_valid), 32'd1);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("s5_busy",      32'(busy),        32'd0);
        check("s5_key_valid", 32'(key_valid),   32'd0);
        check("s5_kc",        32'(key_changed), 32'd0);
        tick();
        check("s5_idle_hold", 32'(busy),        32'd0);

        // Fourth legal char coincides with decrypt_done.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_run("s4_wait_run");
        feed(good_msg, 4, 1'b1);
        tick();
        check("s4_found",      32'(found),      32'd1);
        check("s4_found_key",  32'(found_key),  32'd0);
        check("s4_keys_tried", 32'(keys_tried), 32'd1);

        // Reset in RUN of key 1.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_run("s6_wait_run0");
        feed(bad_msg, 4, 1'b0);
        wait_run("s6_wait_run1");
        check("s6_pre_secret_key", 32'(secret_key), 32'd1);
        reset_n = 1'b0;
        tick();
        check_reset_outputs("s6");
        reset_n = 1'b1;
        tick();

        // Illegal first character 'Z' of key 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_run("s7_wait_run");
        char_valid = 1'b1;
        char_data  = 8'h5A;
        tick();
        char_valid = 1'b0;
`ifdef EARLY_REJECT_EN
        check("s7_next_key_valid", 32'(key_valid),   32'd0);
        check("s7_next_busy",      32'(busy),        32'd1);
        check("s7_next_kc",        32'(key_changed), 32'd0);
        check("s7_keys_tried",     32'(keys_tried),  32'd1);
        tick();
`else
        check("s7_still_run",      32'(key_valid),   32'd1);
        check("s7_tried_before",   32'(keys_tried),  32'd0);
        decrypt_done = 1'b1;
        tick();
        decrypt_done = 1'b0;
        tick();
        tick();
`endif
        check("s7_load_kc",        32'(key_changed), 32'd1);
        check("s7_load_key",       32'(secret_key),  32'd1);
        check("s7_load_tried",     32'(keys_tried),  32'd1);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
